// File: rtl/seq_multiply_n.sv
// Shift-and-add sequential multiplier, N x N -> 2N, signed/unsigned.
// Operands load and product reads go over a BUS_W-bit slice bus.
//
// Ports:
//   MUL_CLK         clock, rising edge
//   RST_N           synchronous reset, active-low
//   DIN             operand load slice
//   LOAD_A, LOAD_B  write DIN into operand slice SEL (IDLE only)
//   SEL             slice index for loads and product readout
//   START           begin multiply of current A and B (IDLE only)
//   SIGNED          two's-complement mode, sampled at START accept
//   BUSY            multiply in progress
//   DONE            product valid, sticky
//   DOUT            product slice SEL (combinational)
module seq_multiply_n #(
    parameter  int N      = 8,
    parameter  int BUS_W  = 4,
    localparam int SLICES = 2 * N / BUS_W,
    localparam int SEL_W  = ($clog2(SLICES) > 1) ? $clog2(SLICES) : 1
) (
    input  logic             MUL_CLK,
    input  logic             RST_N,
    input  logic [BUS_W-1:0] DIN,
    input  logic             LOAD_A,
    input  logic             LOAD_B,
    input  logic [SEL_W-1:0] SEL,
    input  logic             START,
    input  logic             SIGNED,
    output logic             BUSY,
    output logic             DONE,
    output logic [BUS_W-1:0] DOUT
);

    localparam int LD_SLICES = N / BUS_W;
    localparam int CNT_W     = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_mcand;
    logic [N-1:0]     r_mplier;
    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;
    logic             r_done;

    logic             w_load_ok;
    logic             w_start_ok;
    logic             w_last;
    logic [31:0]      w_sel32;
    logic             w_ld_sel_ok;
    logic             w_rd_sel_ok;
    logic             w_a_sgn;
    logic             w_b_sgn;
    logic [N-1:0]     w_a_mag;
    logic [N-1:0]     w_b_mag;
    logic [2*N-1:0]   w_addend;
    logic [2*N-1:0]   w_acc_nxt;

    assign w_sel32     = 32'(SEL);
    assign w_ld_sel_ok = (w_sel32 < 32'(LD_SLICES));
    assign w_rd_sel_ok = (w_sel32 < 32'(SLICES));

    // In signed mode negative operands are reduced to magnitudes; the
    // most negative value maps onto itself and still reads correctly
    // as an unsigned magnitude.
    assign w_a_sgn = SIGNED & r_a[N-1];
    assign w_b_sgn = SIGNED & r_b[N-1];
    assign w_a_mag = w_a_sgn ? -r_a : r_a;
    assign w_b_mag = w_b_sgn ? -r_b : r_b;

    assign w_addend  = r_mplier[0] ?
                       ({{N{1'b0}}, r_mcand} << r_cnt) : '0;
    assign w_acc_nxt = r_acc + w_addend;

    always_comb begin
        w_state_nxt = r_state;
        w_load_ok   = 1'b0;
        w_start_ok  = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_load_ok = 1'b1;
                if (START) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge MUL_CLK) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_ok && w_ld_sel_ok) begin
                if (LOAD_A)
                    r_a[w_sel32*BUS_W +: BUS_W] <= DIN;
                if (LOAD_B)
                    r_b[w_sel32*BUS_W +: BUS_W] <= DIN;
                if (LOAD_A || LOAD_B)
                    r_done <= 1'b0;
            end
            // Working copies take A/B from before this edge, so a
            // same-edge load only affects the next START.
            if (w_start_ok) begin
                r_mcand  <= w_a_mag;
                r_mplier <= w_b_mag;
                r_neg    <= w_a_sgn ^ w_b_sgn;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_done   <= 1'b0;
            end
            if (r_state == S_RUN) begin
                r_acc    <= w_acc_nxt;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_prod <= r_neg ? -w_acc_nxt : w_acc_nxt;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign BUSY = (r_state == S_RUN);
    assign DONE = r_done;
    assign DOUT = w_rd_sel_ok ? r_prod[w_sel32*BUS_W +: BUS_W] : '0;

endmodule

// File: tb/tb_seq_multiply_n.sv
// Directed self-checking bench for seq_multiply_n.
// Covers N=8 (main) and N=16 (wide) instances.
module tb_seq_multiply_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] din = '0;
    logic       load_a = 1'b0;
    logic       load_b = 1'b0;
    logic [1:0] sel = '0;
    logic       start = 1'b0;
    logic       sgn = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] dout;

    logic [3:0] din2 = '0;
    logic       la2 = 1'b0;
    logic       lb2 = 1'b0;
    logic [2:0] sel2 = '0;
    logic       st2 = 1'b0;
    logic       sg2 = 1'b0;
    logic       busy2;
    logic       done2;
    logic [3:0] dout2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_multiply_n #(.N(8), .BUS_W(4)) u_dut (
        .MUL_CLK(clk), .RST_N(rst_n), .DIN(din),
        .LOAD_A(load_a), .LOAD_B(load_b), .SEL(sel),
        .START(start), .SIGNED(sgn), .BUSY(busy),
        .DONE(done), .DOUT(dout)
    );

    seq_multiply_n #(.N(16), .BUS_W(4)) u_dut16 (
        .MUL_CLK(clk), .RST_N(rst_n), .DIN(din2),
        .LOAD_A(la2), .LOAD_B(lb2), .SEL(sel2),
        .START(st2), .SIGNED(sg2), .BUSY(busy2),
        .DONE(done2), .DOUT(dout2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_op(input bit is_b, input logic [7:0] v);
        for (int s = 0; s < 2; s++) begin
            load_a = !is_b;
            load_b = is_b;
            sel    = 2'(s);
            din    = v[s*4 +: 4];
            step();
        end
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    task automatic run(input logic s, output logic b0, output int cyc);
        start = 1'b1;
        sgn   = s;
        step();
        start = 1'b0;
        sgn   = 1'b0;
        b0    = busy;
        cyc   = 0;
        while (busy && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic read_prod(output logic [15:0] p);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            p[s*4 +: 4] = dout;
        end
    endtask

    task automatic test_reset();
        logic [15:0] p;
        rst_n = 1'b0;
        step();
        step();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got busy=%b done=%b exp 0 0",
                     busy, done);
        end
        read_prod(p);
        n_tests++;
        if (p !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_dout got %h exp 0000", p);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_unsigned();
        logic        b0;
        int          cyc;
        logic [15:0] p;
        logic [3:0]  exp_sl [4];
        exp_sl = '{4'h1, 4'h0, 4'hE, 4'hF};
        load_op(1'b0, 8'hFF);
        load_op(1'b1, 8'hFF);
        run(1'b0, b0, cyc);
        n_tests++;
        if (b0 !== 1'b1 || cyc !== 8) begin
            n_fail++;
            $display("FAIL uns_busy got b0=%b cycles=%0d exp 1 8",
                     b0, cyc);
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL uns_done got %b exp 1", done);
        end
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            n_tests++;
            if (dout !== exp_sl[s]) begin
                n_fail++;
                $display("FAIL uns_slice%0d got %h exp %h",
                         s, dout, exp_sl[s]);
            end
        end
        read_prod(p);
        n_tests++;
        if (p !== 16'hFE01) begin
            n_fail++;
            $display("FAIL uns_prod got %h exp FE01", p);
        end
    endtask

    task automatic test_signed();
        logic        b0;
        int          cyc;
        logic [15:0] p;
        load_op(1'b0, 8'h80);
        load_op(1'b1, 8'h7F);
        run(1'b1, b0, cyc);
        read_prod(p);
        n_tests++;
        if (p !== 16'hC080 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL sgn_neg got %h done=%b exp C080 1", p, done);
        end
        load_op(1'b0, 8'hFF);
        load_op(1'b1, 8'hFF);
        run(1'b1, b0, cyc);
        read_prod(p);
        n_tests++;
        if (p !== 16'h0001) begin
            n_fail++;
            $display("FAIL sgn_m1m1 got %h exp 0001", p);
        end
    endtask

    task automatic test_repeat();
        logic        b0;
        int          cyc;
        logic [15:0] p;
        load_op(1'b0, 8'h00);
        load_op(1'b1, 8'hA5);
        run(1'b0, b0, cyc);
        read_prod(p);
        n_tests++;
        if (p !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_prod got %h exp 0000", p);
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done got %b exp 1", done);
        end
        load_op(1'b0, 8'h03);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clr_done got %b exp 0", done);
        end
        run(1'b0, b0, cyc);
        read_prod(p);
        n_tests++;
        if (p !== 16'h01EF) begin
            n_fail++;
            $display("FAIL rep1_prod got %h exp 01EF", p);
        end
        load_a = 1'b1;
        sel    = 2'd2;
        din    = 4'hF;
        step();
        load_a = 1'b0;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL badsel_done got %b exp 1", done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rep2_drop got done=%b busy=%b exp 0 1",
                     done, busy);
        end
        cyc = 0;
        while (busy && cyc < 40) begin
            step();
            cyc++;
        end
        read_prod(p);
        n_tests++;
        if (p !== 16'h01EF || done !== 1'b1 || cyc !== 8) begin
            n_fail++;
            $display("FAIL rep2_prod got %h done=%b cyc=%0d exp 01EF 1 8",
                     p, done, cyc);
        end
    endtask

    task automatic test_midrun();
        int          cyc;
        logic [15:0] p;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        load_a = 1'b1;
        sel    = 2'd0;
        din    = 4'hF;
        start  = 1'b1;
        step();
        load_a = 1'b0;
        start  = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            step();
            cyc++;
        end
        n_tests++;
        if (cyc !== 3) begin
            n_fail++;
            $display("FAIL mid_cycles got %0d exp 3", cyc);
        end
        read_prod(p);
        n_tests++;
        if (p !== 16'h01EF || done !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_prod got %h done=%b exp 01EF 1", p, done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flags got busy=%b done=%b exp 0 0",
                     busy, done);
        end
        read_prod(p);
        n_tests++;
        if (p !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_dout got %h exp 0000", p);
        end
    endtask

    task automatic test_same_cycle();
        logic        b0;
        int          cyc;
        logic [15:0] p;
        load_op(1'b0, 8'h02);
        load_op(1'b1, 8'h03);
        start  = 1'b1;
        load_a = 1'b1;
        sel    = 2'd0;
        din    = 4'h1;
        step();
        start  = 1'b0;
        load_a = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            step();
            cyc++;
        end
        read_prod(p);
        n_tests++;
        if (p !== 16'h0006) begin
            n_fail++;
            $display("FAIL same_prod got %h exp 0006", p);
        end
        run(1'b0, b0, cyc);
        read_prod(p);
        n_tests++;
        if (p !== 16'h0003) begin
            n_fail++;
            $display("FAIL same_next got %h exp 0003", p);
        end
    endtask

    task automatic test_wide();
        logic [15:0] a = 16'hFFFF;
        logic [15:0] b = 16'h0002;
        logic [31:0] p;
        int          cyc;
        for (int s = 0; s < 4; s++) begin
            la2  = 1'b1;
            lb2  = 1'b1;
            sel2 = 3'(s);
            din2 = a[s*4 +: 4];
            step();
            la2  = 1'b0;
            din2 = b[s*4 +: 4];
            step();
            lb2  = 1'b0;
        end
        st2 = 1'b1;
        step();
        st2 = 1'b0;
        cyc = 0;
        while (busy2 && cyc < 60) begin
            step();
            cyc++;
        end
        n_tests++;
        if (cyc !== 16 || done2 !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_lat got cyc=%0d done=%b exp 16 1",
                     cyc, done2);
        end
        for (int s = 0; s < 8; s++) begin
            sel2 = 3'(s);
            #1;
            p[s*4 +: 4] = dout2;
        end
        n_tests++;
        if (p !== 32'h0001FFFE) begin
            n_fail++;
            $display("FAIL wide_prod got %h exp 0001FFFE", p);
        end
        sel2 = 3'd4;
        #1;
        n_tests++;
        if (dout2 !== 4'h1) begin
            n_fail++;
            $display("FAIL wide_sel4 got %h exp 1", dout2);
        end
        sel2 = 3'd7;
        #1;
        n_tests++;
        if (dout2 !== 4'h0) begin
            n_fail++;
            $display("FAIL wide_sel7 got %h exp 0", dout2);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_repeat();
        test_midrun();
        test_same_cycle();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiply_n.md
Name: seq_multiply_n

Overview:
- Parametrised shift-and-add sequential multiplier. It is the next generation of the 4x4 nibble-bus multiplier.
- Operands of N bits are loaded slice-by-slice over a BUS_W-bit data bus. The product of 2N bits is read back slice-by-slice.
- Adds a START/BUSY/DONE handshake, a signed/unsigned mode, persistent operand registers and a proper synchronous reset.
- Sits on the same narrow data bus as the rest of the datapath, as a multi-cycle arithmetic unit.

Parameters:
- N, 8, operand width in bits; must be a multiple of BUS_W and >= BUS_W.
- BUS_W, 4, data bus width; operand load and product readout slice width.
- Derived, not overridable: SLICES = 2*N/BUS_W; SEL_W = max(1, clog2(SLICES)).

Ports:
- MUL_CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  synchronous reset, active-low.
- DIN  in  BUS_W  operand load data.
- LOAD_A  in  1  write DIN into operand A slice SEL.
- LOAD_B  in  1  write DIN into operand B slice SEL.
- SEL  in  SEL_W  slice index for loads (0..N/BUS_W-1, slice 0 = LSBs) and readout (0..SLICES-1).
- START  in  1  begin multiply of current A and B.
- SIGNED  in  1  1 = two's-complement operands; sampled only on the START-accept edge.
- BUSY  out  1  multiply in progress.
- DONE  out  1  product valid, sticky.
- DOUT  out  BUS_W  product slice SEL; combinational mux of the product register.

Behaviour:
- Reset: RST_N low at an edge -> A=0, B=0, product=0, working regs=0, state IDLE, BUSY=0, DONE=0, DOUT=0 for any SEL. Applies mid-operation; the aborted product is discarded.
- States: IDLE and RUN. Iteration counter counts 0..N-1.
- Loads:
  - Accepted only in IDLE.
  - LOAD_A and LOAD_B may both be high; both are written from the same DIN/SEL.
  - A load SEL >= N/BUS_W is ignored.
  - An accepted load clears DONE; the product register is not cleared.
- START accept (IDLE only):
  - Working multiplicand/multiplier are copied from A and B as they were before this edge. A same-edge load still updates A/B, for the next START.
  - SIGNED=1: each operand with MSB set is replaced by its two's-complement magnitude. 2^(N-1) fits in N unsigned bits.
  - The negate flag is set to signA XOR signB.
  - Accumulator is cleared; DONE<=0, BUSY<=1, state RUN.
- RUN, one iteration per edge:
  - If multiplier LSB=1, accumulator += multiplicand << iteration.
  - Multiplier shifts right by one.
  - Accumulator is 2N bits; unsigned magnitude product cannot overflow.
- The N-th RUN edge does all of the following:
  - product <= negate ? -acc (mod 2^2N) : acc.
  - BUSY<=0, DONE<=1, state IDLE.
- Latency: START-accept edge = edge 0; DONE and the product are visible after edge N. BUSY is high for exactly N cycles.
- Ignored inputs:
  - START while BUSY; no restart.
  - LOAD_A/LOAD_B while BUSY.
  - START and LOAD in the same IDLE cycle: both act, as above.
- DONE stays 1 until the next START accept, an accepted load, or reset.
- Product holds its value until the next completion. Operands A/B persist, so a repeated START without reloading recomputes the same product.
- DOUT = product[SEL*BUS_W +: BUS_W]. DOUT=0 for SEL >= SLICES. DOUT is valid in any state and shows the last completed product.

Test Plan:
1. N=8, unsigned, A=0xFF, B=0xFF, START -> BUSY high 8 cycles; DONE after edge 8; product 0xFE01; SEL=0..3 gives DOUT 1,0,E,F.
2. SIGNED=1, A=0x80 (-128), B=0x7F -> product 0xC080 (-16256). Then A=B=0xFF signed -> product 0x0001.
3. A=0x00, B=0xA5 unsigned -> 0x0000. Then load A=0x03, START, then START again with no reload -> 0x01EF both times; DONE drops for one run.
4. Mid-run (after edge 4), LOAD_A/START pulses -> ignored, final product unchanged. Then RST_N low for one edge at iteration 5 of a new run -> BUSY=0, DONE=0, DOUT=0 for all SEL.
5. START and LOAD_A (SEL=0, DIN=0x1) in the same IDLE cycle with A=0x02, B=0x03 -> product 0x0006. A reads back as 0x01 via the next START -> 0x0003.
6. N=16, BUS_W=4, A=0xFFFF, B=0x0002 unsigned -> DONE after edge 16, product 0x0001FFFE. SEL=4 gives DOUT 0x1; SEL=7 gives DOUT 0x0.
